// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - read-side valid/ready handshake between uart_rx_fifo and the CPU
interface uart_rx_fifo_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (output data_out, output data_out_valid, input data_out_ready);
  modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a byte FIFO, with sticky frame/overflow flags
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit and a parity_err flag.
module uart_rx_fifo #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_in,
  uart_rx_fifo_if.master              rd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_busy,
  output logic                        frame_err,
  output logic                        overflow_err,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  input  logic                        err_clear
);
  localparam int CLOCKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME    = CLOCKS_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta, rx_s;
  logic             push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic             par_ok_q, par_ok_d, parity_set;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             pop, push_ok, overflow_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_ok_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q  <= par_ok_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d   = par_ok_q;
    parity_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          state_d    = STOP;
          par_ok_d   = ~^{shift_q, rx_s};
          parity_set = ^{shift_q, rx_s};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Back to IDLE at the stop-bit midpoint so the next start edge is caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push_req = par_ok_q;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_busy           = (state_q != IDLE);
  assign rd.data_out_valid = (count_q != '0);
  assign rd.data_out       = rd.data_out_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count        = count_q;

  // A pop in the same cycle frees the slot the incoming byte needs.
  assign pop          = rd.data_out_valid && rd.data_out_ready;
  assign push_ok      = push_req && ((count_q != DEPTH_C) || pop);
  assign overflow_set = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (overflow_set)   overflow_err <= 1'b1;
      else if (err_clear) overflow_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (parity_set)     parity_err <= 1'b1;
      else if (err_clear) parity_err <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 27_000;
  localparam int DEPTH    = 8;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  // Start-bit drive to data_out_valid: 2 sync flops, IDLE detect, half bit, 9 full bits.
  localparam int LAT      = HALF + 9 * CPB + 3;
  localparam int LAT_MAX  = (19 * CPB) / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       err_clear = 1'b0;
  logic [3:0] fifo_count;
  logic       rx_busy, frame_err, overflow_err;

  uart_rx_fifo_if rd();

  uart_rx_fifo #(
    .CPU_CLOCK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .rd(rd),
    .fifo_count(fifo_count),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .overflow_err(overflow_err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic       exp_frame = 1'b0;
  logic       exp_over  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    serial_in = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) step();
    end
    serial_in = stop;
    repeat (CPB) step();
    serial_in = 1'b1;
    repeat (gap) step();
  endtask

  function automatic void apply_frame(input logic [7:0] b, input logic stop);
    if (!stop)                    exp_frame = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                          exp_over = 1'b1;
  endfunction

  task automatic check_status(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(rd.data_out_valid), 32'(exp_q.size() != 0));
    chk({tag, "_data"}, 32'(rd.data_out), 32'(head));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_frame));
    chk({tag, "_overflow_err"}, 32'(overflow_err), 32'(exp_over));
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    chk({tag, "_head"}, 32'(rd.data_out), 32'(head));
    rd.data_out_ready = 1'b1;
    step();
    rd.data_out_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    exp_frame = 1'b0;
    exp_over  = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       saw_busy;
    logic [7:0] b;
    logic       stop;

    rd.data_out_ready = 1'b0;
    repeat (3) step();
    check_status("reset");
    chk("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b1;
    repeat (3) step();

    // Single byte, latency from the start edge.
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, CPB);
      begin
        while (!rd.data_out_valid && lat < LAT_MAX + 10) begin
          step();
          lat++;
        end
      end
    join
    chk("t1_latency_in_window", 32'(lat <= LAT_MAX && lat + 2 >= LAT), 32'd1);
    apply_frame(8'h55, 1'b1);
    check_status("t1");
    pop_one("t1_pop");
    check_status("t1_drained");

    // Glitch shorter than half a bit is a false start.
    saw_busy  = 1'b0;
    serial_in = 1'b0;
    repeat (HALF / 2) begin
      step();
      saw_busy |= rx_busy;
    end
    serial_in = 1'b1;
    repeat (CPB) begin
      step();
      saw_busy |= rx_busy;
    end
    chk("t2_busy_seen", 32'(saw_busy), 32'd1);
    chk("t2_busy_idle", 32'(rx_busy), 32'd0);
    check_status("t2");

    // Bad stop bit.
    send_frame(8'hA3, 1'b0, CPB);
    apply_frame(8'hA3, 1'b0);
    check_status("t3");
    clear_errors();
    check_status("t3_clr");

    // Back-to-back frames into a full FIFO.
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 0);
      apply_frame(8'(i), 1'b1);
    end
    repeat (CPB) step();
    check_status("t4_full");
    for (int i = 0; i < DEPTH; i++) pop_one("t4_drain");
    check_status("t4_empty");
    clear_errors();
    check_status("t4_clr");

    // Random fill, then a pop landing on the stop-bit sample of one more byte.
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 2);
      apply_frame(b, 1'b1);
    end
    check_status("t5_full");
    fork
      send_frame(8'h42, 1'b1, CPB);
      begin
        repeat (LAT - 1) step();
        chk("t5_old_head", 32'(rd.data_out), 32'(exp_q[0]));
        rd.data_out_ready = 1'b1;
        step();
        rd.data_out_ready = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    apply_frame(8'h42, 1'b1);
    check_status("t5_after");
    for (int i = 0; i < DEPTH; i++) pop_one("t5_drain");
    check_status("t5_empty");

    // Random bytes with occasional bad stop bits.
    for (int i = 0; i < 5; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, CPB);
      apply_frame(b, stop);
    end
    check_status("t7");
    while (exp_q.size() != 0) pop_one("t7_drain");
    check_status("t7_empty");
    clear_errors();

    // Reset in the middle of bit 4 with a byte already queued.
    b = 8'($urandom);
    send_frame(b, 1'b1, CPB);
    apply_frame(b, 1'b1);
    check_status("t6_pre");
    b = 8'($urandom);
    serial_in = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 4; i++) begin
      serial_in = b[i];
      repeat (CPB) step();
    end
    serial_in = b[4];
    repeat (HALF) step();
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_frame = 1'b0;
    exp_over  = 1'b0;
    check_status("t6_in_reset");
    chk("t6_busy_in_reset", 32'(rx_busy), 32'd0);
    serial_in = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    repeat (5) step();
    send_frame(8'h7E, 1'b1, CPB);
    apply_frame(8'h7E, 1'b1);
    check_status("t6");
    pop_one("t6_pop");
    check_status("t6_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Memory-mapped serial receive front end that sits between the FPGA_SERIAL_RX pin and the CPU's load path. It synchronises the raw line and decodes 8N1 frames with a mid-bit sampling FSM. Received bytes are buffered in a small FIFO, which the CPU's memory-mapped IO decode drains through a valid/ready handshake. Sticky framing and overflow flags are exposed for a status register.

Parameters:
CPU_CLOCK_FREQ, 50_000_000, core clock in Hz
BAUD_RATE, 115200, line rate in bit/s
FIFO_DEPTH, 8, byte entries; must be a power of 2, minimum 2
Derived: CLOCKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE (integer division; 434 at defaults)
Derived: SAMPLE_TIME = CLOCKS_PER_BIT / 2 (217 at defaults)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
serial_in  input  1  raw RX line; idles high
data_out  output  8  FIFO head byte; 0 when empty
data_out_valid  output  1  FIFO not empty
data_out_ready  input  1  CPU pops the head when valid && ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
rx_busy  output  1  FSM is not in IDLE
frame_err  output  1  sticky; a stop bit was sampled 0
overflow_err  output  1  sticky; a byte was dropped because the FIFO was full
err_clear  input  1  single-cycle pulse clears both sticky flags

Behaviour:
- Reset (rst=0, async): both synchroniser flops = 1; FSM = IDLE; baud counter = 0; bit index = 0; shift register = 0; FIFO empty with pointers = 0. Resulting outputs: data_out = 0, data_out_valid = 0, fifo_count = 0, rx_busy = 0, frame_err = 0, overflow_err = 0. A partial frame in flight is discarded.
- Synchroniser: 2 flops. The FSM only ever sees rx_s, the second flop.
- FSM states:
  - IDLE: rx_s = 0 -> go to START, counter = 0.
  - START: count up. At counter == SAMPLE_TIME-1, sample rx_s:
    - rx_s = 1: false start, return to IDLE with no flag.
    - rx_s = 0: go to DATA, counter = 0, bit index = 0.
  - DATA: at counter == CLOCKS_PER_BIT-1, shift rx_s in LSB-first and reset the counter. After bit index 7 is taken, go to STOP.
  - STOP: at counter == CLOCKS_PER_BIT-1, sample rx_s, then return to IDLE in the same cycle.
    - rx_s = 1: push the byte.
    - rx_s = 0: set frame_err; no push.
- Returning to IDLE at the stop-bit midpoint leaves half a bit of margin for back-to-back frames.
- Push rule: a push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow_err is set.
- Pop: data_out_valid && data_out_ready advances the read pointer. A pop while empty is ignored.
- Simultaneous push and pop: fifo_count is unchanged. The popped byte is the old head.
- Latency: the pushed byte appears on data_out/data_out_valid the cycle after the stop-bit sample.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count saturates neither up nor down; the push/pop rules keep it in range.
- Sticky flags: err_clear clears both. If err_clear and a set event land in the same cycle, set wins.
- rx_busy = (state != IDLE). It is combinational from registered state.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP.
  - One extra bit is sampled at CLOCKS_PER_BIT-1 and checked for even parity over the 8 data bits plus the parity bit.
  - On mismatch: sticky output parity_err (1 bit) is set and the byte is not pushed, even if the stop bit is good.
  - err_clear also clears parity_err; reset value is 0.
- Undefined: no PARITY state and no parity_err port. Frames are 8N1 exactly.

Test Plan:
1. Defaults, drive 0x55 as 8N1 at 434 clk/bit, ready=0 -> valid rises within 9.5*434+3 cycles of the start edge; data_out=0x55, fifo_count=1; a ready pulse empties the FIFO (count=0, data_out=0).
2. Glitch serial_in low for 100 cycles, then high -> rx_busy pulses, then returns to IDLE; no push; no flags set.
3. Send 0xA3 with stop bit forced 0 -> frame_err=1, count=0; err_clear pulse -> frame_err=0.
4. ready=0, send bytes 0x00..0x08 back-to-back -> count=8, overflow_err=1; draining yields 0x00..0x07 in order, then valid=0.
5. FIFO full (8 entries), assert ready so the pop coincides with the next byte's stop sample (0x42) -> push accepted, count stays 8, overflow_err stays 0; 0x42 emerges last.
6. Assert rst low at mid-bit 4 of a frame, release, then send 0x7E -> all outputs at reset values during reset; the next read returns exactly 0x7E, count=1.
